load_store_unit: RTL and testbench

- Memory-access stage between the execute stage and the unified instruction/data memory. Drives the data-side port (data_memory_a/read/write/out_v) and consumes data_memory_in_v.
- Turns byte, halfword and word load/store requests into word-wide memory accesses. Sub-word stores use read-modify-write.
- Memory byte order is big-endian: byte at word address A+0 maps to bits [31:24]. Alignment and range faults are detected here.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response channel between execute and the LSU, and the LSU's data-side memory port.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

interface load_store_unit_mem_if;
  logic [31:0] data_memory_a;
  logic        data_memory_read;
  logic        data_memory_write;
  logic [31:0] data_memory_out_v;
  logic [31:0] data_memory_in_v;

  modport master (
    output data_memory_a, data_memory_read, data_memory_write, data_memory_out_v,
    input  data_memory_in_v
  );
  modport slave (
    input  data_memory_a, data_memory_read, data_memory_write, data_memory_out_v,
    output data_memory_in_v
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores on a big-endian word memory, RMW for sub-word stores.
// Latency (READ_LATENCY=1): fault 1, load 2, word store 2, sub-word store 4; one request in flight, no response backpressure.
module load_store_unit #(
  parameter int MEM_BYTES    = 65536,
  parameter int READ_LATENCY = 1
) (
  input logic                  Clk,
  input logic                  Reset_n,
  load_store_unit_if.slave     req,
  load_store_unit_mem_if.master mem
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  localparam logic [1:0]  RD_LAST   = 2'(READ_LATENCY - 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] rd_word;
  logic [1:0]  rd_cnt;

  logic [31:0] mem_a;
  logic [31:0] mem_out;
  logic        mem_rd;
  logic        mem_wr;
  logic        resp_vld;
  logic        resp_flt;
  logic [31:0] resp_dat;

  logic [32:0] size_bytes;
  logic        req_fault;

  // Byte offset 0 is the most significant lane; ~off selects the lane index from the LSB end.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{~off, 3'b000} +: 8];
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] size,
                                        input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (size == 2'b00)
      r[{~off, 3'b000} +: 8] = d[7:0];
    else if (off[1])
      r[15:0] = d[15:0];
    else
      r[31:16] = d[15:0];
    return r;
  endfunction

  always_comb begin
    case (req.req_size)
      2'b01:   size_bytes = 33'd2;
      2'b10:   size_bytes = 33'd4;
      default: size_bytes = 33'd1;
    endcase
    req_fault = (req.req_size == 2'b11)
             || (req.req_size == 2'b01 && req.req_addr[0])
             || (req.req_size == 2'b10 && req.req_addr[1:0] != 2'b00)
             || ({1'b0, req.req_addr} + size_bytes > MEM_LIMIT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_wdata  <= '0;
      rd_word  <= '0;
      rd_cnt   <= 2'b00;
      mem_a    <= '0;
      mem_out  <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      resp_vld <= 1'b0;
      resp_flt <= 1'b0;
      resp_dat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            r_write  <= req.req_write;
            r_size   <= req.req_size;
            r_signed <= req.req_signed;
            r_off    <= req.req_addr[1:0];
            r_wdata  <= req.req_wdata;
            rd_cnt   <= 2'b00;
            if (req_fault) begin
              state    <= RESP;
              resp_vld <= 1'b1;
              resp_flt <= 1'b1;
              resp_dat <= '0;
            end else begin
              mem_a <= {req.req_addr[31:2], 2'b00};
              if (req.req_write && req.req_size == 2'b10) begin
                state   <= WR;
                mem_wr  <= 1'b1;
                mem_out <= req.req_wdata;
              end else begin
                state  <= RD;
                mem_rd <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (rd_cnt == RD_LAST) begin
            mem_rd  <= 1'b0;
            rd_word <= mem.data_memory_in_v;
            if (r_write) begin
              state <= MERGE;
            end else begin
              state    <= RESP;
              resp_vld <= 1'b1;
              resp_flt <= 1'b0;
              resp_dat <= extract(mem.data_memory_in_v, r_size, r_off, r_signed);
            end
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        MERGE: begin
          mem_out <= merge(rd_word, r_size, r_off, r_wdata);
          mem_wr  <= 1'b1;
          state   <= WR;
        end
        WR: begin
          mem_wr   <= 1'b0;
          state    <= RESP;
          resp_vld <= 1'b1;
          resp_flt <= 1'b0;
          resp_dat <= '0;
        end
        RESP: begin
          state    <= IDLE;
          resp_vld <= 1'b0;
          resp_flt <= 1'b0;
          resp_dat <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req.req_ready          = (state == IDLE) && Reset_n;
  assign req.resp_valid         = resp_vld;
  assign req.resp_rdata         = resp_dat;
  assign req.resp_fault         = resp_flt;
  assign mem.data_memory_a      = mem_a;
  assign mem.data_memory_read   = mem_rd;
  assign mem.data_memory_write  = mem_wr;
  assign mem.data_memory_out_v  = mem_out;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array memory model behind the data port.
module tb_load_store_unit;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  load_store_unit_if     req_if ();
  load_store_unit_mem_if mem_if ();

  load_store_unit #(.MEM_BYTES(65536), .READ_LATENCY(1)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .req     (req_if.slave),
    .mem     (mem_if.master)
  );

  logic [31:0] mem [0:16383];
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_both = 0;
  logic [31:0] last_rd_a = '0;
  logic [31:0] last_wr_a = '0;
  logic [31:0] last_wr_dat = '0;

  assign mem_if.data_memory_in_v = mem[mem_if.data_memory_a[15:2]];

  always @(posedge Clk) begin
    if (mem_if.data_memory_read) begin
      n_rd      <= n_rd + 1;
      last_rd_a <= mem_if.data_memory_a;
    end
    if (mem_if.data_memory_write) begin
      n_wr        <= n_wr + 1;
      last_wr_a   <= mem_if.data_memory_a;
      last_wr_dat <= mem_if.data_memory_out_v;
      mem[mem_if.data_memory_a[15:2]] <= mem_if.data_memory_out_v;
    end
    if (mem_if.data_memory_read && mem_if.data_memory_write)
      n_both <= n_both + 1;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic flt);
    int guard;
    guard = 0;
    while (!req_if.req_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!req_if.req_ready) chk("ready_timeout", 32'(req_if.req_ready), 32'd1);
    req_if.req_write  = w;
    req_if.req_size   = sz;
    req_if.req_signed = sg;
    req_if.req_addr   = ad;
    req_if.req_wdata  = wd;
    req_if.req_valid  = 1'b1;
    step();
    // Scramble inputs after acceptance; the unit must use its registered copy.
    req_if.req_valid  = 1'b0;
    req_if.req_write  = ~w;
    req_if.req_size   = 2'b11;
    req_if.req_signed = ~sg;
    req_if.req_addr   = 32'hFFFF_FFFF;
    req_if.req_wdata  = 32'hDEAD_BEEF;
    lat = 1;
    while (!req_if.resp_valid && lat < 20) begin
      step();
      lat++;
    end
    rd  = req_if.resp_rdata;
    flt = req_if.resp_fault;
  endtask

  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] ad, input logic [31:0] wd, input int e_lat,
                     input logic [31:0] e_rd, input logic e_flt, input int e_nrd, input int e_nwr);
    int lat;
    logic [31:0] rd;
    logic flt;
    int nr;
    int nw;
    nr = n_rd;
    nw = n_wr;
    do_req(w, sz, sg, ad, wd, lat, rd, flt);
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_fault"}, 32'(flt), 32'(e_flt));
    chk({tag, "_rd_cycles"}, 32'(n_rd - nr), 32'(e_nrd));
    chk({tag, "_writes"}, 32'(n_wr - nw), 32'(e_nwr));
  endtask

  task automatic set_bb(input int k);
    req_if.req_valid  = 1'b1;
    req_if.req_signed = 1'b0;
    req_if.req_wdata  = 32'h0;
    case (k)
      0: begin req_if.req_write = 1'b1; req_if.req_size = 2'b10; req_if.req_addr = 32'h300; req_if.req_wdata = 32'hCAFE_F00D; end
      1: begin req_if.req_write = 1'b0; req_if.req_size = 2'b10; req_if.req_addr = 32'h300; end
      default: begin req_if.req_write = 1'b0; req_if.req_size = 2'b00; req_if.req_addr = 32'h301; end
    endcase
  endtask

  initial begin
    int          nw;
    int          i_acc;
    int          cyc;
    int          n_resp;
    logic [31:0] resp_d [3];
    int          resp_c [3];
    logic        any_flt;
    logic        rdy;

    req_if.req_valid  = 1'b0;
    req_if.req_write  = 1'b0;
    req_if.req_size   = 2'b00;
    req_if.req_signed = 1'b0;
    req_if.req_addr   = '0;
    req_if.req_wdata  = '0;

    #2;
    chk("rst_req_ready", 32'(req_if.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(req_if.resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(req_if.resp_fault), 32'd0);
    chk("rst_resp_rdata", req_if.resp_rdata, 32'h0);
    chk("rst_mem_read", 32'(mem_if.data_memory_read), 32'd0);
    chk("rst_mem_write", 32'(mem_if.data_memory_write), 32'd0);
    chk("rst_mem_a", mem_if.data_memory_a, 32'h0);
    chk("rst_mem_out_v", mem_if.data_memory_out_v, 32'h0);
    #10;
    Reset_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(req_if.req_ready), 32'd1);

    // Word store/load and sub-word extraction
    txn("st_w_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, 2, 32'h0, 1'b0, 0, 1);
    chk("st_w_100_addr", last_wr_a, 32'h100);
    txn("ld_w_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2, 32'h1234_5678, 1'b0, 1, 0);
    chk("ld_w_100_addr", last_rd_a, 32'h100);
    txn("ld_b_103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 2, 32'h0000_0078, 1'b0, 1, 0);
    txn("ld_h_102u", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 2, 32'h0000_5678, 1'b0, 1, 0);
    txn("st_w_100b", 1'b1, 2'b10, 1'b0, 32'h100, 32'h9234_5678, 2, 32'h0, 1'b0, 0, 1);
    txn("ld_b_100s", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 2, 32'hFFFF_FF92, 1'b0, 1, 0);
    txn("ld_b_100u", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 2, 32'h0000_0092, 1'b0, 1, 0);
    txn("ld_h_100s", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 2, 32'hFFFF_9234, 1'b0, 1, 0);
    txn("ld_b_102s", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 2, 32'h0000_0056, 1'b0, 1, 0);

    // Read-modify-write sub-word stores
    txn("st_w_200", 1'b1, 2'b10, 1'b0, 32'h200, 32'hAABB_CCDD, 2, 32'h0, 1'b0, 0, 1);
    txn("st_b_201", 1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFF_FF11, 4, 32'h0, 1'b0, 1, 1);
    chk("st_b_201_wr_addr", last_wr_a, 32'h200);
    chk("st_b_201_wr_data", last_wr_dat, 32'hAA11_CCDD);
    txn("ld_w_200a", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 2, 32'hAA11_CCDD, 1'b0, 1, 0);
    txn("st_h_202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_5566, 4, 32'h0, 1'b0, 1, 1);
    chk("st_h_202_wr_data", last_wr_dat, 32'hAA11_5566);
    txn("ld_w_200b", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 2, 32'hAA11_5566, 1'b0, 1, 0);

    // Faults: no memory access, zero data
    txn("flt_w_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("flt_h_301", 1'b1, 2'b01, 1'b0, 32'h301, 32'h1111, 1, 32'h0, 1'b1, 0, 0);
    txn("flt_size3", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("flt_w_fffe", 1'b0, 2'b10, 1'b0, 32'hFFFE, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    txn("flt_w_10000", 1'b1, 2'b10, 1'b0, 32'h1_0000, 32'h5555_5555, 1, 32'h0, 1'b1, 0, 0);

    // Reset while a byte store is in RD
    step();
    nw = n_wr;
    req_if.req_write  = 1'b1;
    req_if.req_size   = 2'b00;
    req_if.req_signed = 1'b0;
    req_if.req_addr   = 32'h200;
    req_if.req_wdata  = 32'h77;
    req_if.req_valid  = 1'b1;
    step();
    req_if.req_valid = 1'b0;
    chk("mid_rst_rd_before", 32'(mem_if.data_memory_read), 32'd1);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_rd_drop", 32'(mem_if.data_memory_read), 32'd0);
    chk("mid_rst_wr_low", 32'(mem_if.data_memory_write), 32'd0);
    chk("mid_rst_ready_low", 32'(req_if.req_ready), 32'd0);
    step();
    step();
    Reset_n = 1'b1;
    #1;
    chk("mid_rst_ready_after", 32'(req_if.req_ready), 32'd1);
    chk("mid_rst_no_write", 32'(n_wr - nw), 32'd0);
    txn("ld_w_200c", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 2, 32'hAA11_5566, 1'b0, 1, 0);

    // Back-to-back with req_valid held high
    step();
    i_acc   = 0;
    cyc     = 0;
    n_resp  = 0;
    any_flt = 1'b0;
    set_bb(0);
    while ((i_acc < 3 || n_resp < 3) && cyc < 60) begin
      rdy = req_if.req_ready;
      step();
      cyc++;
      if (rdy && req_if.req_valid) begin
        i_acc++;
        if (i_acc < 3) set_bb(i_acc);
        else req_if.req_valid = 1'b0;
      end
      if (req_if.resp_valid) begin
        if (n_resp < 3) begin
          resp_d[n_resp] = req_if.resp_rdata;
          resp_c[n_resp] = cyc;
        end
        any_flt = any_flt | req_if.resp_fault;
        n_resp++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      step();
      if (req_if.resp_valid) n_resp++;
    end
    chk("b2b_accepts", 32'(i_acc), 32'd3);
    chk("b2b_resp_count", 32'(n_resp), 32'd3);
    chk("b2b_fault", 32'(any_flt), 32'd0);
    chk("b2b_r0_data", resp_d[0], 32'h0);
    chk("b2b_r1_data", resp_d[1], 32'hCAFE_F00D);
    chk("b2b_r2_data", resp_d[2], 32'h0000_00FE);
    chk("b2b_r0_cyc", 32'(resp_c[0]), 32'd2);
    chk("b2b_r1_cyc", 32'(resp_c[1]), 32'd5);
    chk("b2b_r2_cyc", 32'(resp_c[2]), 32'd8);

    chk("rd_wr_exclusive", 32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
